// File: rtl/sp_pkg.sv
// Shared definitions for the solar-panel scan tracker: state encoding, status
// width and the saturating position-step helper.
package sp_pkg;

    localparam int STAT_W = 3;

    typedef enum logic [STAT_W-1:0] {
        S_IDLE   = 3'd0,
        S_SEEK   = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_STEP   = 3'd4,
        S_RETURN = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    // Move a position one step up or down, clamped to [lo, hi].
    function automatic logic [31:0] sat_move(
        input logic [31:0] pos,
        input logic [31:0] step,
        input logic [31:0] lo,
        input logic [31:0] hi,
        input logic        up
    );
        logic [31:0] r;
        if (up) begin
            if (pos + step > hi) begin
                r = hi;
            end else begin
                r = pos + step;
            end
        end else begin
            if (pos < lo + step) begin
                r = lo;
            end else begin
                r = pos - step;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sp_scan_tracker_if.sv
// Button, sample and status bundle of the scan tracker; the tracker is the
// slave, whoever drives buttons and ADC samples is the master.
interface sp_scan_tracker_if
    import sp_pkg::*;
#(
    parameter int N_AXES = 2,
    parameter int ADC_W  = 12,
    parameter int POS_W  = 18
) ();
    logic [N_AXES-1:0]       BTN_INC;
    logic [N_AXES-1:0]       BTN_DEC;
    logic                    BTN_C;
    logic [ADC_W-1:0]        V_in;
    logic                    V_VALID;
    logic [N_AXES-1:0]       SERVO;
    logic [N_AXES*POS_W-1:0] servo_position;
    logic [ADC_W-1:0]        max_V_in;
    logic [STAT_W-1:0]       STAT;
    logic                    BUSY;

    modport master (
        output BTN_INC, BTN_DEC, BTN_C, V_in, V_VALID,
        input  SERVO, servo_position, max_V_in, STAT, BUSY
    );

    modport slave (
        input  BTN_INC, BTN_DEC, BTN_C, V_in, V_VALID,
        output SERVO, servo_position, max_V_in, STAT, BUSY
    );
endinterface

// File: rtl/sp_servo_pwm.sv
// Servo PWM channel: fixed frame counter, pulse width sampled once per frame
// so a position change can only take effect at a frame boundary.
module sp_servo_pwm #(
    parameter int PWM_PERIOD = 2000000,
    parameter int POS_W      = 18
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [POS_W-1:0] pos_i,
    output logic             pwm_o
);
    localparam int             CNT_W    = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] width_q, width_d;
    logic             pwm_q, pwm_d;

    // Frame counter, width latch at count zero and registered pulse compare.
    always_comb begin
        cnt_d   = cnt_q;
        width_d = width_q;
        pwm_d   = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_q == '0) begin
            width_d = pos_i;
        end else begin
            width_d = width_q;
        end
        pwm_d = (32'(cnt_q) < 32'(width_d));
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q   <= '0;
            width_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            width_q <= width_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/sp_scan_tracker.sv
// Multi-axis servo tracker: manual jog in IDLE, or an automatic per-axis sweep
// that parks each axis at the position giving the highest panel voltage.
module sp_scan_tracker
    import sp_pkg::*;
#(
    parameter int N_AXES     = 2,
    parameter int ADC_W      = 12,
    parameter int POS_W      = 18,
    parameter int PWM_PERIOD = 2000000,
    parameter int POS_MIN    = 100000,
    parameter int POS_MAX    = 200000,
    parameter int POS_STEP   = 1000,
    parameter int SETTLE_CYC = 500000
) (
    input  logic          CLK,
    input  logic          RST_N,
    sp_scan_tracker_if.slave bus
);
    localparam int               CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam int               AX_W        = (N_AXES > 1) ? $clog2(N_AXES) : 1;
    localparam logic [AX_W-1:0]  AX_LAST     = AX_W'(N_AXES - 1);
    localparam logic [POS_W-1:0] POS_MIN_C   = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] POS_MAX_C   = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_RST_C   = POS_W'((POS_MIN + POS_MAX) / 2);

    state_e            state_q, state_d;
    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AX_W-1:0]   a_q, a_d;
    logic [ADC_W-1:0]  best_q, best_d;
    logic [POS_W-1:0]  best_pos_q, best_pos_d;
    logic [POS_W-1:0]  pos_q [N_AXES];
    logic [POS_W-1:0]  pos_d [N_AXES];

    logic [N_AXES-1:0] inc_q, dec_q;
    logic              c_q;
    logic [N_AXES-1:0] inc_edge_s, dec_edge_s;
    logic              c_edge_s;

    assign inc_edge_s = bus.BTN_INC & ~inc_q;
    assign dec_edge_s = bus.BTN_DEC & ~dec_q;
    assign c_edge_s   = bus.BTN_C & ~c_q;

    // Next-state and datapath updates; a scan-button edge outside IDLE aborts
    // and freezes positions and best value.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        best_d     = best_q;
        best_pos_d = best_pos_q;
        pos_d      = pos_q;
        if (c_edge_s && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    for (int k = 0; k < N_AXES; k++) begin
                        if (inc_edge_s[k] && !dec_edge_s[k]) begin
                            pos_d[k] = POS_W'(sat_move(32'(pos_q[k]), 32'(POS_STEP),
                                                       32'(POS_MIN), 32'(POS_MAX), 1'b1));
                        end else if (dec_edge_s[k] && !inc_edge_s[k]) begin
                            pos_d[k] = POS_W'(sat_move(32'(pos_q[k]), 32'(POS_STEP),
                                                       32'(POS_MIN), 32'(POS_MAX), 1'b0));
                        end else begin
                            pos_d[k] = pos_q[k];
                        end
                    end
                    if (c_edge_s) begin
                        best_d  = '0;
                        a_d     = '0;
                        state_d = S_SEEK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_SEEK: begin
                    pos_d[a_q] = POS_MIN_C;
                    best_pos_d = POS_MIN_C;
                    cnt_d      = '0;
                    state_d    = S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = S_SAMPLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (bus.V_VALID) begin
                        // Strict compare: on a tie the earlier position wins.
                        if (bus.V_in > best_q) begin
                            best_d     = bus.V_in;
                            best_pos_d = pos_q[a_q];
                        end else begin
                            best_d = best_q;
                        end
                        state_d = S_STEP;
                    end else begin
                        state_d = S_SAMPLE;
                    end
                end
                S_STEP: begin
                    if (pos_q[a_q] == POS_MAX_C) begin
                        state_d = S_RETURN;
                    end else begin
                        pos_d[a_q] = POS_W'(sat_move(32'(pos_q[a_q]), 32'(POS_STEP),
                                                     32'(POS_MIN), 32'(POS_MAX), 1'b1));
                        cnt_d      = '0;
                        state_d    = S_SETTLE;
                    end
                end
                S_RETURN: begin
                    pos_d[a_q] = best_pos_q;
                    if (a_q < AX_LAST) begin
                        a_d     = a_q + AX_W'(1);
                        best_d  = '0;
                        state_d = S_SEEK;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, datapath and button-history registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            a_q        <= '0;
            best_q     <= '0;
            best_pos_q <= '0;
            inc_q      <= '0;
            dec_q      <= '0;
            c_q        <= 1'b0;
            for (int k = 0; k < N_AXES; k++) begin
                pos_q[k] <= POS_RST_C;
            end
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != S_IDLE);
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            best_q     <= best_d;
            best_pos_q <= best_pos_d;
            inc_q      <= bus.BTN_INC;
            dec_q      <= bus.BTN_DEC;
            c_q        <= bus.BTN_C;
            for (int k = 0; k < N_AXES; k++) begin
                pos_q[k] <= pos_d[k];
            end
        end
    end

    assign bus.STAT     = state_q;
    assign bus.BUSY     = busy_q;
    assign bus.max_V_in = best_q;

    for (genvar k = 0; k < N_AXES; k++) begin : g_axis
        assign bus.servo_position[k*POS_W +: POS_W] = pos_q[k];

        sp_servo_pwm #(
            .PWM_PERIOD (PWM_PERIOD),
            .POS_W      (POS_W)
        ) u_pwm (
            .CLK   (CLK),
            .RST_N (RST_N),
            .pos_i (pos_q[k]),
            .pwm_o (bus.SERVO[k])
        );
    end

endmodule

// File: tb/tb_sp_scan_tracker.sv
// Directed bench for sp_scan_tracker with small parameters: reset/PWM, manual
// jog table, full scan, abort, sample stall and reset during STEP.
module tb_sp_scan_tracker;
    localparam int PW = 18;

    logic CLK = 1'b0;
    logic RST_N;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    sp_scan_tracker_if #(.N_AXES(2), .ADC_W(12), .POS_W(PW)) bus ();

    sp_scan_tracker #(
        .N_AXES(2), .ADC_W(12), .POS_W(PW), .PWM_PERIOD(100),
        .POS_MIN(10), .POS_MAX(50), .POS_STEP(10), .SETTLE_CYC(4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [1:0] inc;
        logic [1:0] dec;
        int         p0;
        int         p1;
    } vec_t;

    vec_t vt[10];
    int   vin_tab[10];
    int   best_tab[10];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pos_of(input int k);
        return 32'(bus.servo_position[k*PW +: PW]);
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_stat"}, 32'(bus.STAT), 32'd0);
        chk({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        chk({tag, "_pos0"}, pos_of(0), 32'd30);
        chk({tag, "_pos1"}, pos_of(1), 32'd30);
        chk({tag, "_servo"}, 32'(bus.SERVO), 32'd0);
        chk({tag, "_max"}, 32'(bus.max_V_in), 32'd0);
    endtask

    initial begin
        int  hi0, hi1, si, done_cnt, not3;
        logic [1:0] first;
        bit  fin, ret_seen, hit;

        vt[0] = '{2'b01, 2'b00, 40, 30};
        vt[1] = '{2'b01, 2'b00, 50, 30};
        vt[2] = '{2'b01, 2'b00, 50, 30};
        vt[3] = '{2'b01, 2'b00, 50, 30};
        vt[4] = '{2'b01, 2'b00, 50, 30};
        vt[5] = '{2'b10, 2'b10, 50, 30};
        vt[6] = '{2'b00, 2'b11, 40, 20};
        vt[7] = '{2'b00, 2'b10, 40, 10};
        vt[8] = '{2'b00, 2'b10, 40, 10};
        vt[9] = '{2'b10, 2'b01, 30, 20};

        RST_N = 1'b0;
        bus.BTN_INC = '0;
        bus.BTN_DEC = '0;
        bus.BTN_C   = 1'b0;
        bus.V_in    = '0;
        bus.V_VALID = 1'b0;
        repeat (3) tick();
        check_reset_values("rst");

        // Reset release and PWM frame
        RST_N = 1'b1;
        hi0 = 0; hi1 = 0; first = 2'b00;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0) first = bus.SERVO;
            if (bus.SERVO[0]) hi0++;
            if (bus.SERVO[1]) hi1++;
        end
        chk("pwm_first", 32'(first), 32'd3);
        chk("pwm_hi0", 32'(hi0), 32'd30);
        chk("pwm_hi1", 32'(hi1), 32'd30);
        chk("idle_stat", 32'(bus.STAT), 32'd0);

        // Manual jog table
        for (int v = 0; v < 10; v++) begin
            bus.BTN_INC = vt[v].inc;
            bus.BTN_DEC = vt[v].dec;
            tick();
            chk($sformatf("jog%0d_pos0", v), pos_of(0), 32'(vt[v].p0));
            chk($sformatf("jog%0d_pos1", v), pos_of(1), 32'(vt[v].p1));
            bus.BTN_INC = '0;
            bus.BTN_DEC = '0;
            tick();
        end
        bus.BTN_INC = 2'b01;
        repeat (3) tick();
        chk("jog_level_once", pos_of(0), 32'd40);
        bus.BTN_INC = '0;
        tick();

        // Full scan
        vin_tab  = '{100, 400, 400, 200, 50, 900, 10, 10, 10, 10};
        best_tab = '{100, 400, 400, 400, 400, 900, 900, 900, 900, 900};
        bus.V_VALID = 1'b1;
        bus.BTN_C = 1'b1;
        tick();
        bus.BTN_C = 1'b0;
        chk("scan_seek", 32'(bus.STAT), 32'd1);
        chk("scan_busy", 32'(bus.BUSY), 32'd1);
        si = 0; done_cnt = 0; fin = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (bus.STAT == 3'd3 && si < 10) bus.V_in = 12'(vin_tab[si]);
            tick();
            if (bus.STAT == 3'd4) begin
                if (si < 10) chk($sformatf("scan_best%0d", si), 32'(bus.max_V_in), 32'(best_tab[si]));
                si++;
            end
            if (bus.STAT == 3'd6) done_cnt++;
            if (done_cnt > 0 && bus.STAT == 3'd0) fin = 1'b1;
        end
        chk("scan_finished", 32'(fin), 32'd1);
        chk("scan_samples", 32'(si), 32'd10);
        chk("scan_done_cycles", 32'(done_cnt), 32'd1);
        chk("scan_pos0", pos_of(0), 32'd20);
        chk("scan_pos1", pos_of(1), 32'd10);
        chk("scan_max", 32'(bus.max_V_in), 32'd900);
        chk("scan_busy_end", 32'(bus.BUSY), 32'd0);

        // Abort during a SETTLE of axis 1
        vin_tab = '{5, 5, 5, 5, 700, 333, 1, 1, 1, 1};
        bus.BTN_C = 1'b1;
        tick();
        bus.BTN_C = 1'b0;
        si = 0; ret_seen = 1'b0; hit = 1'b0;
        for (int c = 0; c < 400 && !hit; c++) begin
            if (bus.STAT == 3'd3 && si < 10) bus.V_in = 12'(vin_tab[si]);
            tick();
            if (bus.STAT == 3'd4) si++;
            if (bus.STAT == 3'd5) ret_seen = 1'b1;
            if (ret_seen && si == 6 && bus.STAT == 3'd2) hit = 1'b1;
        end
        chk("abort_reached", 32'(hit), 32'd1);
        bus.BTN_C = 1'b1;
        tick();
        chk("abort_stat", 32'(bus.STAT), 32'd0);
        chk("abort_busy", 32'(bus.BUSY), 32'd0);
        chk("abort_pos0", pos_of(0), 32'd50);
        chk("abort_pos1", pos_of(1), 32'd20);
        chk("abort_max", 32'(bus.max_V_in), 32'd333);
        repeat (3) tick();
        chk("abort_hold_stat", 32'(bus.STAT), 32'd0);
        chk("abort_hold_pos1", pos_of(1), 32'd20);
        bus.BTN_C = 1'b0;
        tick();

        // Sample stall with V_VALID low
        bus.V_VALID = 1'b0;
        bus.BTN_C = 1'b1;
        tick();
        bus.BTN_C = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            tick();
            if (bus.STAT == 3'd3) hit = 1'b1;
        end
        chk("stall_reached", 32'(hit), 32'd1);
        not3 = 0;
        bus.BTN_INC = 2'b10;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.STAT != 3'd3) not3++;
        end
        bus.BTN_INC = '0;
        chk("stall_hold", 32'(not3), 32'd0);
        chk("busy_manual_ignored", pos_of(1), 32'd20);
        bus.V_VALID = 1'b1;
        bus.V_in = 12'd123;
        tick();
        bus.V_VALID = 1'b0;
        chk("pulse_step", 32'(bus.STAT), 32'd4);
        chk("pulse_max", 32'(bus.max_V_in), 32'd123);
        tick();
        chk("pulse_settle", 32'(bus.STAT), 32'd2);
        chk("pulse_pos0", pos_of(0), 32'd20);

        // Reset while in STEP
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            tick();
            if (bus.STAT == 3'd3) hit = 1'b1;
        end
        chk("step2_reached", 32'(hit), 32'd1);
        bus.V_VALID = 1'b1;
        bus.V_in = 12'd50;
        tick();
        bus.V_VALID = 1'b0;
        chk("step2_stat", 32'(bus.STAT), 32'd4);
        RST_N = 1'b0;
        tick();
        check_reset_values("midrst");
        RST_N = 1'b1;
        tick();
        chk("post_rst_stat", 32'(bus.STAT), 32'd0);
        chk("post_rst_servo", 32'(bus.SERVO), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sp_scan_tracker.md
SP_SCAN_TRACKER -- requirements
Module: sp_scan_tracker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
- N_AXES, 2, number of servo axes.
- ADC_W, 12, V_in width.
- POS_W, 18, position/pulse-width width in clock cycles.
- PWM_PERIOD, 2000000, servo frame length in cycles.
- POS_MIN, 100000, minimum pulse width.
- POS_MAX, 200000, maximum pulse width.
- POS_STEP, 1000, position increment.
- SETTLE_CYC, 500000, wait after each move before sampling.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK, in, 1, system clock.
- RST_N, in, 1, synchronous active-low reset.
- BTN_INC, in, N_AXES, manual increase per axis (level; rising edge acts).
- BTN_DEC, in, N_AXES, manual decrease per axis.
- BTN_C, in, 1, rising edge starts a scan, or aborts a running one.
- V_in, in, ADC_W, panel voltage sample.
- V_VALID, in, 1, V_in valid strobe.
- SERVO, out, N_AXES, PWM outputs.
- servo_position, out, N_AXES*POS_W, current positions; axis k at bits [k*POS_W +: POS_W].
- max_V_in, out, ADC_W, best sample of the last or current scan.
- STAT, out, 3, FSM state code.
- BUSY, out, 1, high outside IDLE.

Function
REQ-004 The FSM SHALL have states IDLE=0, SEEK=1, SETTLE=2, SAMPLE=3, STEP=4, RETURN=5, DONE=6.
REQ-005 Every button input SHALL be registered once and acted on only on its rising edge.
REQ-006 In IDLE, a BTN_INC[k] edge SHALL set pos[k]=min(pos[k]+POS_STEP, POS_MAX), and a BTN_DEC[k] edge SHALL set pos[k]=max(pos[k]-POS_STEP, POS_MIN).
REQ-007 Simultaneous INC and DEC edges on the same axis SHALL leave that position unchanged; edges on different axes SHALL apply independently.
REQ-008 A BTN_C edge in IDLE SHALL clear max_V_in and best, set axis index a=0, and enter SEEK.
REQ-009 SEEK SHALL set pos[a]=POS_MIN and enter SETTLE.
REQ-010 SETTLE SHALL count SETTLE_CYC cycles and then enter SAMPLE.
REQ-011 SAMPLE SHALL wait for V_VALID and then apply the update rule.
- If V_in > best (strict), set best=V_in and best_pos=pos[a]; ties keep the earlier position.
- max_V_in SHALL track best.
- Then go to STEP.
REQ-012 STEP transitions:
- If pos[a]==POS_MAX, go to RETURN.
- Otherwise set pos[a]=min(pos[a]+POS_STEP, POS_MAX) and go to SETTLE.
REQ-013 RETURN SHALL set pos[a]=best_pos and then take one branch:
- If a<N_AXES-1: a=a+1, clear best, go to SEEK.
- Otherwise go to DONE.
- max_V_in keeps the last axis's best.
REQ-014 DONE SHALL last exactly one cycle and then go to IDLE.
REQ-015 A BTN_C edge in any non-IDLE state SHALL abort to IDLE on the next cycle.
- Positions hold their current values.
- max_V_in holds.
REQ-016 Manual buttons SHALL be ignored outside IDLE.
REQ-017 Each PWM SHALL use a 0..PWM_PERIOD-1 frame counter.
- The output is high while count < latched width.
- The width is latched from pos at count==0, so mid-frame position changes never glitch a pulse.
REQ-018 BUSY SHALL be (STAT != IDLE).

Reset
REQ-019 On RST_N=0 at a CLK edge, the block SHALL reset as follows:
- Each pos SHALL be (POS_MIN+POS_MAX)/2, truncated.
- Frame counters and latched widths SHALL be 0, so SERVO=0.
- max_V_in, best and a SHALL be 0.
- STAT SHALL be IDLE and BUSY SHALL be 0.
- Button history registers SHALL be 0.
REQ-020 Reset mid-scan SHALL override all other activity in that cycle.

Structure
REQ-021 State codes, the STAT width and a position-saturation helper SHALL live in package sp_pkg.
REQ-022 The PWM SHALL be sub-module sp_servo_pwm (params PWM_PERIOD, POS_W), instantiated N_AXES times via a generate loop.

Verification
Bench params for all scenarios: PWM_PERIOD=100, POS_MIN=10, POS_MAX=50, POS_STEP=10, SETTLE_CYC=4, N_AXES=2.
REQ-023 Reset, then release -> both positions 30, SERVO high for 30 of every 100 cycles starting in the first frame after release, STAT=0.
REQ-024 Five BTN_INC[0] edges -> pos0 40, 50, 50, 50, 50 (saturated); INC[1] and DEC[1] in the same cycle -> pos1 stays 30.
REQ-025 BTN_C, V_in per sample on axis 0 = {100,400,400,200,50}, axis 1 = {900,10,10,10,10}, V_VALID always 1 -> positions end at pos0=20 (tie keeps first) and pos1=10, max_V_in=900, DONE for one cycle, then STAT=0.
REQ-026 BTN_C during SETTLE of axis 1 -> IDLE the next cycle, pos0 at its best, pos1 unchanged, BUSY=0.
REQ-027 Hold V_VALID=0 in SAMPLE -> STAT stays 3 indefinitely; a single V_VALID pulse -> STEP the next cycle.
REQ-028 Assert RST_N=0 mid-STEP -> all outputs at REQ-019 values the cycle after.
